datamover_mm2s_reader: RTL and testbench
========================================

DATAMOVER_MM2S_READER -- requirements
Module: datamover_mm2s_reader

Interface
REQ-001 SHALL have parameter BUF_BASE, default 32'h0000_0000, DDR byte address of the capture ring buffer.
REQ-002 SHALL have parameter BUF_BLOCKS, default 2048, ring depth in blocks; power of two, at most 32768.
REQ-003 SHALL have parameter BLOCK_BYTES, default 4096, bytes per block (256 beats of 16 B).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, maximum commands issued without status.
REQ-005 SHALL have ports (name direction width meaning), clock and reset first:
 axi_aclk in 1 sole clock;
 axi_aresetn in 1 reset, synchronous, active-low;
 enable in 1 readback enable;
 wr_block_ptr in 16 free-running count of blocks committed by the ADC writer;
 rd_block_ptr out 16 free-running count of blocks issued for read;
 cmd_tdata out 72, cmd_tvalid out 1, cmd_tready in 1: DataMover MM2S command stream;
 sts_tdata in 8, sts_tvalid in 1, sts_tready out 1: MM2S status stream;
 mm2s_tdata in 128, mm2s_tvalid in 1, mm2s_tlast in 1, mm2s_tready out 1: read data from DataMover;
 m_axis_tdata out 128, m_axis_tvalid out 1, m_axis_tlast out 1, m_axis_tready in 1: sample stream to consumer;
 overrun out 1 sticky, writer lapped reader;
 err out 1 sticky, DataMover error status.

Function
REQ-006 SHALL implement states IDLE, SYNC, ISSUE, DRAIN, HALT.
REQ-007 IDLE: enable=1 -> SYNC.
REQ-008 SYNC: rd_block_ptr <= wr_block_ptr; -> ISSUE next cycle.
REQ-009 ISSUE: when cmd_tvalid=0, (wr_block_ptr - rd_block_ptr) mod 2^16 != 0 and outstanding < MAX_OUTSTANDING, SHALL assert cmd_tvalid next cycle with the command for rd_block_ptr.
REQ-010 Command fields: [22:0] BTT=BLOCK_BYTES; [23]=1 INCR; [29:24]=0; [30]=1 EOF; [31]=0; [63:32]=BUF_BASE + (rd_block_ptr mod BUF_BLOCKS)*BLOCK_BYTES; [67:64]=rd_block_ptr[3:0] tag; [71:68]=0.
REQ-011 cmd_tvalid and cmd_tdata SHALL hold stable until cmd_tready; on handshake rd_block_ptr increments by 1 (wraps 16'hFFFF->0) and outstanding increments.
REQ-012 Overrun: in ISSUE with cmd_tvalid=0 and (wr_block_ptr - rd_block_ptr) mod 2^16 >= BUF_BLOCKS, SHALL set overrun, -> SYNC, issuing nothing that cycle.
REQ-013 sts_tready SHALL be 1 in every state after reset; each status beat decrements outstanding; command handshake and status beat in the same cycle leave outstanding unchanged.
REQ-014 Status with any of bits [6:4] set, or bit [7]=0, SHALL set err and -> HALT.
REQ-015 enable=0 in ISSUE: a pending cmd_tvalid completes its handshake, then -> DRAIN; DRAIN -> IDLE when outstanding=0.
REQ-016 HALT: no commands; data path keeps draining; leaves to IDLE only when enable=0; err clears on that transition.
REQ-017 overrun SHALL clear on IDLE->SYNC.
REQ-018 Data path SHALL be a 2-entry skid buffer: mm2s_tready = not full; tdata/tlast forwarded in order, unmodified; latency 1 cycle; no beat dropped or duplicated under any m_axis_tready pattern; full throughput when m_axis_tready=1.
REQ-019 Data path SHALL be independent of FSM state.

Reset
REQ-020 axi_aresetn=0 at a clock edge SHALL force: state IDLE, rd_block_ptr 0, outstanding 0, cmd_tvalid 0, cmd_tdata 0, m_axis_tvalid 0, m_axis_tlast 0, skid buffer empty, overrun 0, err 0; sts_tready 0 during reset; mid-operation reset discards in-flight data.

Structure
REQ-021 Shared package SHALL hold: state enum, DataMover command field offsets, status bit positions, BEAT_BYTES=16.
REQ-022 Skid buffer SHALL be sub-module axis_skid_buffer (128-bit data + last).

Verification
REQ-023 Reset, enable=1, wr_block_ptr=3 -> SYNC sets rd=3; wr->5 -> two commands, SADDR 0x3000 and 0x4000, BTT 4096, tags 3,4.
REQ-024 cmd_tready held 0 for 10 cycles -> cmd_tdata stable; single handshake; rd_block_ptr +1.
REQ-025 wr=rd+10, no status returned -> exactly 4 commands; one OKAY status (0x80) -> exactly one more.
REQ-026 rd=2047 with BUF_BLOCKS=2048 -> SADDR 0x7FF000, then 0x0; rd 16'hFFFF->0 wrap keeps issuing.
REQ-027 wr jumps to rd+2048 -> overrun=1, rd_block_ptr=wr_block_ptr, no command that cycle; status 0x41 -> err=1, HALT, no further commands.
REQ-028 256 beats with random m_axis_tready -> output identical sequence, tlast only on beat 256.

Source files
------------

// File: rtl/datamover_mm2s_reader_pkg.sv
// Shared types and DataMover MM2S command/status field layout for the capture-buffer reader.
package datamover_mm2s_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ISSUE,
        ST_DRAIN,
        ST_HALT
    } state_e;

    localparam int BEAT_BYTES = 16;

    localparam int CMD_W          = 72;
    localparam int CMD_BTT_LSB    = 0;
    localparam int CMD_BTT_W      = 23;
    localparam int CMD_TYPE_BIT   = 23;
    localparam int CMD_EOF_BIT    = 30;
    localparam int CMD_SADDR_LSB  = 32;
    localparam int CMD_TAG_LSB    = 64;

    localparam int STS_INTERR_BIT = 4;
    localparam int STS_SLVERR_BIT = 6;
    localparam int STS_OKAY_BIT   = 7;

    // INCR burst, EOF set, DSA/DRR/reserved left zero.
    function automatic logic [CMD_W-1:0] make_cmd(input logic [31:0] saddr,
                                                  input logic [22:0] btt,
                                                  input logic [3:0]  tag);
        logic [CMD_W-1:0] c;
        c = '0;
        c[CMD_BTT_LSB +: CMD_BTT_W] = btt;
        c[CMD_TYPE_BIT]             = 1'b1;
        c[CMD_EOF_BIT]              = 1'b1;
        c[CMD_SADDR_LSB +: 32]      = saddr;
        c[CMD_TAG_LSB +: 4]         = tag;
        return c;
    endfunction

    function automatic logic sts_is_error(input logic [7:0] sts);
        return (sts[STS_SLVERR_BIT:STS_INTERR_BIT] != 3'b000) || !sts[STS_OKAY_BIT];
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer: registered output, full throughput, ready = not full.
module axis_skid_buffer #(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready
);

    logic [DATA_W:0] mem_q [2];
    logic [DATA_W:0] mem_d [2];
    logic            wr_idx_q, wr_idx_d;
    logic            rd_idx_q, rd_idx_d;
    logic [1:0]      count_q, count_d;
    logic            push, pop;

    assign s_ready = (count_q != 2'd2);
    assign m_valid = (count_q != 2'd0);
    assign m_data  = mem_q[rd_idx_q][DATA_W-1:0];
    assign m_last  = m_valid && mem_q[rd_idx_q][DATA_W];

    always_comb begin
        push     = s_valid && s_ready;
        pop      = m_valid && m_ready;
        mem_d    = mem_q;
        wr_idx_d = wr_idx_q ^ push;
        rd_idx_d = rd_idx_q ^ pop;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_idx_q] = {s_last, s_data};
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/datamover_mm2s_reader.sv
// Reads committed capture blocks back from the DDR ring via DataMover MM2S and streams them out.
module datamover_mm2s_reader
    import datamover_mm2s_reader_pkg::*;
#(
    parameter logic [31:0] BUF_BASE        = 32'h0000_0000,
    parameter int unsigned BUF_BLOCKS      = 2048,
    parameter int unsigned BLOCK_BYTES     = 4096,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic         axi_aclk,
    input  logic         axi_aresetn,
    input  logic         enable,
    input  logic [15:0]  wr_block_ptr,
    output logic [15:0]  rd_block_ptr,
    output logic [71:0]  cmd_tdata,
    output logic         cmd_tvalid,
    input  logic         cmd_tready,
    input  logic [7:0]   sts_tdata,
    input  logic         sts_tvalid,
    output logic         sts_tready,
    input  logic [127:0] mm2s_tdata,
    input  logic         mm2s_tvalid,
    input  logic         mm2s_tlast,
    output logic         mm2s_tready,
    output logic [127:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    output logic         m_axis_tlast,
    input  logic         m_axis_tready,
    output logic         overrun,
    output logic         err
);

    localparam int              OUT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [15:0]     IDX_MASK  = 16'(BUF_BLOCKS - 1);
    localparam logic [16:0]     LAP_LIMIT = 17'(BUF_BLOCKS);
    localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);

    state_e             state_q, state_d;
    logic [15:0]        rd_ptr_q, rd_ptr_d;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [CMD_W-1:0]   cmd_data_q, cmd_data_d;
    logic               overrun_q, overrun_d;
    logic               err_q, err_d;
    logic               sts_ready_q, sts_ready_d;

    logic [15:0]        lag;
    logic [31:0]        blk_addr;
    logic               cmd_hs, sts_hs, sts_bad;

    assign rd_block_ptr = rd_ptr_q;
    assign cmd_tvalid   = cmd_valid_q;
    assign cmd_tdata    = cmd_data_q;
    assign sts_tready   = sts_ready_q;
    assign overrun      = overrun_q;
    assign err          = err_q;

    // NOTE: every signal driven here gets its default first, so no path can leave one unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        outstanding_d = outstanding_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_data_d    = cmd_data_q;
        overrun_d     = overrun_q;
        err_d         = err_q;
        sts_ready_d   = 1'b1;

        lag      = wr_block_ptr - rd_ptr_q;
        blk_addr = BUF_BASE + 32'(rd_ptr_q & IDX_MASK) * 32'(BLOCK_BYTES);
        cmd_hs   = cmd_valid_q && cmd_tready;
        sts_hs   = sts_tvalid && sts_ready_q;
        sts_bad  = sts_hs && sts_is_error(sts_tdata);

        // A command already presented always completes, whatever the state.
        if (cmd_hs) begin
            cmd_valid_d = 1'b0;
            rd_ptr_d    = rd_ptr_q + 16'd1;
        end

        case ({cmd_hs, sts_hs})
            2'b10: outstanding_d = outstanding_q + OUT_W'(1);
            2'b01: if (outstanding_q != '0) outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d   = ST_SYNC;
                    overrun_d = 1'b0;
                end
            end
            ST_SYNC: begin
                rd_ptr_d = wr_block_ptr;
                state_d  = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!enable) begin
                    if (!cmd_valid_q || cmd_hs) state_d = ST_DRAIN;
                end else if (!cmd_valid_q) begin
                    if ({1'b0, lag} >= LAP_LIMIT) begin
                        overrun_d = 1'b1;
                        state_d   = ST_SYNC;
                    end else if (lag != 16'd0 && outstanding_q < OUT_MAX) begin
                        cmd_valid_d = 1'b1;
                        cmd_data_d  = make_cmd(blk_addr, 23'(BLOCK_BYTES), rd_ptr_q[3:0]);
                    end
                end
            end
            ST_DRAIN: begin
                if (outstanding_q == '0) state_d = ST_IDLE;
            end
            ST_HALT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (sts_bad) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
        end
    end

    // NOTE: sequential state is updated only with <=, so every flop sees pre-edge values of the others.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state_q       <= ST_IDLE;
            rd_ptr_q      <= 16'd0;
            outstanding_q <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_data_q    <= '0;
            overrun_q     <= 1'b0;
            err_q         <= 1'b0;
            sts_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            outstanding_q <= outstanding_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_data_q    <= cmd_data_d;
            overrun_q     <= overrun_d;
            err_q         <= err_d;
            sts_ready_q   <= sts_ready_d;
        end
    end

    axis_skid_buffer #(
        .DATA_W (8 * BEAT_BYTES)
    ) u_skid (
        .clk     (axi_aclk),
        .rst_n   (axi_aresetn),
        .s_data  (mm2s_tdata),
        .s_last  (mm2s_tlast),
        .s_valid (mm2s_tvalid),
        .s_ready (mm2s_tready),
        .m_data  (m_axis_tdata),
        .m_last  (m_axis_tlast),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

endmodule

// File: tb/tb_datamover_mm2s_reader.sv
// Directed bench for datamover_mm2s_reader: command scoreboard, stream scoreboard, literal pins.
module tb_datamover_mm2s_reader;

    logic         axi_aclk      = 1'b0;
    logic         axi_aresetn   = 1'b0;
    logic         enable        = 1'b0;
    logic [15:0]  wr_block_ptr  = 16'd0;
    logic [15:0]  rd_block_ptr;
    logic [71:0]  cmd_tdata;
    logic         cmd_tvalid;
    logic         cmd_tready    = 1'b0;
    logic [7:0]   sts_tdata     = 8'h00;
    logic         sts_tvalid    = 1'b0;
    logic         sts_tready;
    logic [127:0] mm2s_tdata    = '0;
    logic         mm2s_tvalid   = 1'b0;
    logic         mm2s_tlast    = 1'b0;
    logic         mm2s_tready;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready = 1'b0;
    logic         overrun;
    logic         err;

    always #5 axi_aclk = ~axi_aclk;

    datamover_mm2s_reader #(
        .BUF_BASE        (32'h0000_0000),
        .BUF_BLOCKS      (2048),
        .BLOCK_BYTES     (4096),
        .MAX_OUTSTANDING (4)
    ) dut (
        .axi_aclk      (axi_aclk),
        .axi_aresetn   (axi_aresetn),
        .enable        (enable),
        .wr_block_ptr  (wr_block_ptr),
        .rd_block_ptr  (rd_block_ptr),
        .cmd_tdata     (cmd_tdata),
        .cmd_tvalid    (cmd_tvalid),
        .cmd_tready    (cmd_tready),
        .sts_tdata     (sts_tdata),
        .sts_tvalid    (sts_tvalid),
        .sts_tready    (sts_tready),
        .mm2s_tdata    (mm2s_tdata),
        .mm2s_tvalid   (mm2s_tvalid),
        .mm2s_tlast    (mm2s_tlast),
        .mm2s_tready   (mm2s_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .overrun       (overrun),
        .err           (err)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0]  model_next = 16'd0;
    int           model_out  = 0;
    logic [71:0]  cmd_log [$];
    logic [128:0] exp_q [$];
    int           beats_out  = 0;
    int           lasts_out  = 0;
    logic         hold_pend  = 1'b0;
    logic [71:0]  hold_data  = '0;
    bit           rand_ready = 1'b0;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Command for a block: ring slot * block size, BTT 4096, INCR, EOF, tag = low nibble.
    function automatic logic [71:0] exp_cmd(input logic [15:0] blk);
        logic [31:0] addr;
        addr = 32'(blk % 16'd2048) * 32'd4096;
        return {4'h0, blk[3:0], addr, 8'h40, 24'h80_1000};
    endfunction

    function automatic logic [127:0] beat_data(input int i);
        return {32'(i), ~32'(i), 32'(i * 3), 32'hA5A5_0000 | 32'(i)};
    endfunction

    always @(negedge axi_aclk) begin
        if (!axi_aresetn) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("cmd_hold_valid", cmd_tvalid, 1'b1);
                check("cmd_hold_data", cmd_tdata, hold_data);
            end
            hold_pend = cmd_tvalid && !cmd_tready;
            hold_data = cmd_tdata;
            if (cmd_tvalid && cmd_tready) begin
                check("cmd_window", model_out < 4, 1'b1);
                check("cmd_model", cmd_tdata, exp_cmd(model_next));
                cmd_log.push_back(cmd_tdata);
                model_next++;
                model_out++;
            end
            if (sts_tvalid && sts_tready && model_out > 0) model_out--;
            if (mm2s_tvalid && mm2s_tready) exp_q.push_back({mm2s_tlast, mm2s_tdata});
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 1'b1, 1'b0);
                end else begin
                    check("beat", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
                end
                beats_out++;
                if (m_axis_tlast) lasts_out++;
            end
        end
    end

    always begin
        @(posedge axi_aclk);
        #1;
        if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge axi_aclk);
        #1;
    endtask

    task automatic send_status(input logic [7:0] v);
        int n;
        n = 0;
        sts_tdata  = v;
        sts_tvalid = 1'b1;
        do begin
            @(negedge axi_aclk);
            n++;
        end while (!sts_tready && n < 50);
        if (!sts_tready) check("sts_timeout", 1'b0, 1'b1);
        @(posedge axi_aclk);
        #1;
        sts_tvalid = 1'b0;
    endtask

    task automatic send_beats(input int n, input bit gaps, output int cyc);
        int   i;
        int   guard;
        logic hs;
        logic pend;
        i = 0; guard = 0; cyc = 0; pend = 1'b0;
        while (i < n && guard < 4000) begin
            if (!pend && gaps && $urandom_range(0, 3) == 0) begin
                mm2s_tvalid = 1'b0;
            end else begin
                mm2s_tvalid = 1'b1;
                mm2s_tdata  = beat_data(i);
                mm2s_tlast  = (i == n - 1);
            end
            @(negedge axi_aclk);
            hs   = mm2s_tvalid && mm2s_tready;
            pend = mm2s_tvalid && !mm2s_tready;
            @(posedge axi_aclk);
            #1;
            cyc++; guard++;
            if (hs) i++;
        end
        mm2s_tvalid = 1'b0;
        mm2s_tlast  = 1'b0;
        if (i < n) check("beat_send_timeout", i, n);
    endtask

    initial begin
        int base;
        int cyc;
        int b0;
        int l0;

        #200_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int cyc;
        int b0;
        int l0;

        // Reset state
        cycles(3);
        check("rst_sts_tready", sts_tready, 1'b0);
        check("rst_rd_ptr", rd_block_ptr, 16'd0);
        check("rst_cmd_tvalid", cmd_tvalid, 1'b0);
        check("rst_cmd_tdata", cmd_tdata, 72'h0);
        check("rst_m_tvalid", m_axis_tvalid, 1'b0);
        check("rst_flags", {overrun, err}, 2'b00);
        axi_aresetn = 1'b1;
        cycles(1);
        check("sts_tready_up", sts_tready, 1'b1);

        // Sync to wr=3, then two blocks
        cmd_tready   = 1'b1;
        wr_block_ptr = 16'd3;
        model_next   = 16'd3;
        enable       = 1'b1;
        cycles(5);
        check("sync_rd", rd_block_ptr, 16'd3);
        check("sync_no_cmd", cmd_log.size(), 0);
        wr_block_ptr = 16'd5;
        cycles(8);
        check("two_cmds", cmd_log.size(), 2);
        if (cmd_log.size() >= 2) begin
            check("cmd0_literal", cmd_log[0], 72'h3_0000_3000_4080_1000);
            check("cmd1_literal", cmd_log[1], 72'h4_0000_4000_4080_1000);
        end
        check("rd_after_two", rd_block_ptr, 16'd5);
        send_status(8'h80);
        send_status(8'h80);

        // Back-pressure on the command stream
        cmd_tready   = 1'b0;
        wr_block_ptr = 16'd6;
        cycles(2);
        check("bp_valid", cmd_tvalid, 1'b1);
        check("bp_literal", cmd_tdata, 72'h5_0000_5000_4080_1000);
        cycles(10);
        check("bp_no_hs", cmd_log.size(), 2);
        check("bp_rd_hold", rd_block_ptr, 16'd5);
        cmd_tready = 1'b1;
        cycles(1);
        check("bp_single_hs", cmd_log.size(), 3);
        check("bp_rd_inc", rd_block_ptr, 16'd6);
        send_status(8'h80);

        // Outstanding limit
        base = cmd_log.size();
        wr_block_ptr = 16'd16;
        cycles(20);
        check("limit_four", cmd_log.size(), base + 4);
        check("limit_rd", rd_block_ptr, 16'd10);
        send_status(8'h80);
        cycles(10);
        check("limit_one_more", cmd_log.size(), base + 5);
        enable = 1'b0;
        cycles(2);
        repeat (4) send_status(8'h80);
        cycles(4);
        check("drain_no_cmd", cmd_log.size(), base + 5);

        // Ring wrap at slot 2047 and pointer wrap at 16'hFFFF
        wr_block_ptr = 16'd2047;
        model_next   = 16'd2047;
        enable       = 1'b1;
        cycles(5);
        check("ring_sync", rd_block_ptr, 16'd2047);
        base = cmd_log.size();
        wr_block_ptr = 16'd2049;
        cycles(8);
        check("ring_two", cmd_log.size(), base + 2);
        if (cmd_log.size() >= base + 2) begin
            check("ring_last_slot", cmd_log[base], 72'hF_007F_F000_4080_1000);
            check("ring_first_slot", cmd_log[base + 1], 72'h0_0000_0000_4080_1000);
        end
        repeat (2) send_status(8'h80);
        enable = 1'b0;
        cycles(4);
        wr_block_ptr = 16'hFFFE;
        model_next   = 16'hFFFE;
        enable       = 1'b1;
        cycles(5);
        base = cmd_log.size();
        wr_block_ptr = 16'h0001;
        cycles(10);
        check("ptr_wrap_cmds", cmd_log.size(), base + 3);
        check("ptr_wrap_rd", rd_block_ptr, 16'h0001);
        repeat (3) send_status(8'h80);
        enable = 1'b0;
        cycles(4);

        // Overrun, then error status
        wr_block_ptr = 16'd100;
        model_next   = 16'd100;
        enable       = 1'b1;
        cycles(5);
        check("ovr_clear", overrun, 1'b0);
        base = cmd_log.size();
        wr_block_ptr = 16'd2148;
        model_next   = 16'd2148;
        cycles(4);
        check("ovr_set", overrun, 1'b1);
        check("ovr_resync", rd_block_ptr, 16'd2148);
        check("ovr_no_cmd", cmd_log.size(), base);
        wr_block_ptr = 16'd2149;
        cycles(4);
        check("ovr_next_cmd", cmd_log.size(), base + 1);
        if (cmd_log.size() >= base + 1) check("ovr_cmd_literal", cmd_log[base], 72'h4_0006_4000_4080_1000);
        send_status(8'h41);
        cycles(2);
        check("err_set", err, 1'b1);
        wr_block_ptr = 16'd2152;
        cycles(10);
        check("halt_no_cmd", cmd_log.size(), base + 1);
        enable = 1'b0;
        cycles(3);
        check("err_clear", err, 1'b0);
        check("ovr_sticky", overrun, 1'b1);
        model_next = 16'd2152;
        enable     = 1'b1;
        cycles(3);
        check("ovr_cleared_sync", overrun, 1'b0);
        enable = 1'b0;
        cycles(4);

        // 256-beat block under random consumer back-pressure
        b0 = beats_out;
        l0 = lasts_out;
        rand_ready = 1'b1;
        send_beats(256, 1'b1, cyc);
        cycles(40);
        rand_ready    = 1'b0;
        m_axis_tready = 1'b1;
        cycles(4);
        check("blk_beats", beats_out - b0, 256);
        check("blk_lasts", lasts_out - l0, 1);
        check("blk_empty", exp_q.size(), 0);

        // Throughput with consumer always ready
        b0 = beats_out;
        send_beats(32, 1'b0, cyc);
        cycles(3);
        check("tput_cycles", cyc, 32);
        check("tput_beats", beats_out - b0, 32);

        // Reset with data held in the skid buffer
        m_axis_tready = 1'b0;
        send_beats(2, 1'b0, cyc);
        check("full_ready", mm2s_tready, 1'b0);
        axi_aresetn = 1'b0;
        cycles(2);
        check("mid_rst_valid", m_axis_tvalid, 1'b0);
        check("mid_rst_last", m_axis_tlast, 1'b0);
        check("mid_rst_ready", mm2s_tready, 1'b1);
        exp_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
